// File: rtl/four_bit_rca_rcs.sv
// 4-bit ripple-carry adder with combinational sum/carry and a registered
// C/V/N/Z status-flag register.
module four_bit_rca_rcs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout,
  output logic       C_q,
  output logic       V_q,
  output logic       N_q,
  output logic       Z_q
);

  localparam int unsigned W = 4;

  // carry[i] is the carry into bit i; carry[W] is the carry out of the MSB
  logic [W:0] carry;
  logic       ovf;

  // Ripple chain of full-adder cells, bit 0 first
  always_comb begin
    carry    = '0;
    S        = '0;
    carry[0] = Cin;
    for (int i = 0; i < W; i++) begin
      S[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  // Carry out and signed overflow (carry into MSB differs from carry out)
  always_comb begin
    Cout = carry[W];
    ovf  = carry[W] ^ carry[W-1];
  end

  // Status flags, captured every cycle, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C_q <= 1'b0;
      V_q <= 1'b0;
      N_q <= 1'b0;
      Z_q <= 1'b0;
    end else begin
      C_q <= carry[W];
      V_q <= ovf;
      N_q <= S[W-1];
      Z_q <= (S == W'(0));
    end
  end

endmodule

// File: tb/tb_four_bit_rca_rcs.sv
// Scoreboard bench for four_bit_rca_rcs: the stimulus process pushes
// hand-computed expectations, a monitor pops and checks after each edge.
module tb_four_bit_rca_rcs;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       C_q;
  logic       V_q;
  logic       N_q;
  logic       Z_q;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] s;
    logic       cout;
    logic       v;
    logic       n;
    logic       z;
    string      nm;
  } exp_t;

  exp_t sb_q[$];

  four_bit_rca_rcs dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .C_q  (C_q),
    .V_q  (V_q),
    .N_q  (N_q),
    .Z_q  (Z_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Drive one vector at the current (falling) edge and queue its expectation
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [3:0] es, input logic ec, input logic ev,
                       input logic en, input logic ez, input string nm);
    exp_t e;
    A   = a;
    B   = b;
    Cin = cin;
    e.s = es; e.cout = ec; e.v = ev; e.n = en; e.z = ez; e.nm = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: flags become visible just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.nm, ".S"},    S,            e.s);
        chk({e.nm, ".Cout"}, {3'b0, Cout}, {3'b0, e.cout});
        chk({e.nm, ".C_q"},  {3'b0, C_q},  {3'b0, e.cout});
        chk({e.nm, ".V_q"},  {3'b0, V_q},  {3'b0, e.v});
        chk({e.nm, ".N_q"},  {3'b0, N_q},  {3'b0, e.n});
        chk({e.nm, ".Z_q"},  {3'b0, Z_q},  {3'b0, e.z});
      end
    end
  end

  // Stimulus
  initial begin
    int budget;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    A = 4'h0; B = 4'h0; Cin = 1'b0;
    #3;
    chk("reset_flags", {C_q, V_q, N_q, Z_q}, 4'b0000);
    chk("reset_comb_S", S, 4'h0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    //     A      B      Cin   S      Cout  V     N     Z
    issue(4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, "add3_5");
    @(negedge clk);
    issue(4'hD, 4'hB, 1'b0, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, "add_m3_m5");
    @(negedge clk);
    issue(4'h8, 4'hD, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, "sub8_2");
    @(negedge clk);
    issue(4'hC, 4'h1, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, "sub_m4_m2");
    @(negedge clk);
    issue(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, "ff_ff_c1");
    @(negedge clk);
    issue(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, "zero");
    @(negedge clk);
    issue(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, "add7_1");
    @(negedge clk);
    issue(4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, "propagate");
    @(negedge clk);
    issue(4'h6, 4'h4, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, "add6_4_c1");
    @(negedge clk);
    issue(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, "wrap");

    // Mid-cycle reset with C and Z set
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_flags", {C_q, V_q, N_q, Z_q}, 4'b0000);
    chk("rst_S_hold", S, 4'h0);
    chk("rst_Cout_hold", {3'b0, Cout}, 4'b0001);
    A = 4'h3; B = 4'h5; Cin = 1'b0;
    #1;
    chk("rst_S_track", S, 4'h8);
    chk("rst_Cout_track", {3'b0, Cout}, 4'b0000);
    @(posedge clk);
    #2;
    chk("rst_hold_flags", {C_q, V_q, N_q, Z_q}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_no_capture", {C_q, V_q, N_q, Z_q}, 4'b0000);
    issue(4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, "post_reset");

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
